// File: rtl/sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its benches.
package sequencer_pkg;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ERROR = 2'b11
  } seq_state_t;

  // Opcode field II in bits [15:14] of an instruction word
  localparam logic [1:0] MV   = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;
  localparam logic [1:0] MULT = 2'b11;
endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; pointers carry one wrap bit beyond the index so
// full and empty are distinguished without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/instr_sequencer.sv
// Buffers host instructions and issues them one at a time to the processor,
// counting retirements and latching a sticky error if the processor hangs.
//
// state | meaning
// IDLE  | waiting for a queued word; pops the FIFO head into instr_q
// ISSUE | proc_run pulse, timeout counter cleared
// WAIT  | waiting for proc_done, timeout counter running
// ERROR | processor hung; absorbing until reset
module instr_sequencer
  import sequencer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [INSTR_W-1:0] proc_instr,
  output logic               proc_run,
  input  logic               proc_done,
  output logic               busy,
  output logic [7:0]         retired,
  output logic               error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] fifo_head;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [7:0]         retired_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               retire;

  sync_fifo #(
    .WIDTH(INSTR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid),
    .push_data(in_instr),
    .pop      (pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (pop)    instr_q   <= fifo_head;
      if (retire) retired_q <= retired_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    pop     = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (proc_done) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TLIM) state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = !fifo_full;
  assign proc_instr = instr_q;
  assign proc_run   = (state_q == ISSUE);
  assign error      = (state_q == ERROR);
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign retired    = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a two-register processor model answers run
// pulses, and expectations come from the pushed program and timing rules.
module tb_instr_sequencer;
  import sequencer_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic [15:0] proc_instr;
  logic        proc_run;
  logic        proc_done;
  logic        busy;
  logic [7:0]  retired;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  // processor model state
  logic        stall = 1'b0;
  logic        spurious = 1'b0;
  logic        model_done;
  int          pcnt;
  logic [15:0] pinstr;
  logic [15:0] r [2];
  logic        prev_run;
  logic        b2b = 1'b0;
  int          run_count = 0;
  int          cyc = 0;
  logic [15:0] issued_q[$];
  logic [15:0] done_instr_q[$];
  int          run_cyc_q[$];
  logic [15:0] pushed_q[$];

  assign proc_done = model_done | spurious;

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .proc_instr(proc_instr),
    .proc_run  (proc_run),
    .proc_done (proc_done),
    .busy      (busy),
    .retired   (retired),
    .error     (error)
  );

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      MV:      return b;
      ADD:     return a + b;
      SUB:     return a - b;
      default: return a * b;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // mv answers one cycle after the run edge, ALU ops three cycles after
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_done <= 1'b0;
      pcnt       <= 0;
      prev_run   <= 1'b0;
      pinstr     <= '0;
      r[0]       <= '0;
      r[1]       <= '0;
    end else begin
      prev_run   <= proc_run;
      model_done <= 1'b0;
      if (proc_run && prev_run) b2b <= 1'b1;
      if (proc_done) done_instr_q.push_back(proc_instr);
      if (proc_run) begin
        issued_q.push_back(proc_instr);
        run_cyc_q.push_back(cyc);
        run_count <= run_count + 1;
        pinstr    <= proc_instr;
        pcnt      <= (proc_instr[15:14] == MV) ? 1 : 3;
      end else if (pcnt != 0 && !stall) begin
        if (pcnt == 1) begin
          model_done <= 1'b1;
          r[pinstr[12]] <= alu(pinstr[15:14], r[pinstr[12]],
                               pinstr[13] ? {4'h0, pinstr[11:0]} : r[pinstr[0]]);
        end
        pcnt <= pcnt - 1;
      end
    end
  end

  task automatic clear_logs();
    issued_q.delete();
    done_instr_q.delete();
    run_cyc_q.delete();
    pushed_q.delete();
    b2b = 1'b0;
    run_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic push(input logic [15:0] w, output logic acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = w;
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [15:0] w);
    logic acc;
    int n;
    n = 0;
    do begin
      push(w, acc);
      n++;
    end while (!acc && n < 200);
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL push_accept: word %h never accepted, want accepted", w);
    end else pushed_q.push_back(w);
  endtask

  task automatic wait_retired(input logic [7:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (retired !== target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (retired !== target) begin
      miscompares++;
      $display("FAIL %s: retired got %0d want %0d", name, retired, target);
    end
  endtask

  // Issued and done-cycle words must both equal the pushed program in order
  task automatic check_order(input string name);
    vectors++;
    if (issued_q.size() != pushed_q.size() || done_instr_q.size() != pushed_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: issued %0d done %0d want %0d", name,
               issued_q.size(), done_instr_q.size(), pushed_q.size());
    end else begin
      for (int i = 0; i < pushed_q.size(); i++) begin
        vectors++;
        if (issued_q[i] !== pushed_q[i] || done_instr_q[i] !== pushed_q[i]) begin
          miscompares++;
          $display("FAIL %s_word%0d: issued %h at done %h want %h", name, i,
                   issued_q[i], done_instr_q[i], pushed_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({in_ready, proc_run, proc_instr, busy, retired, error} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: ready %b run %b instr %h busy %b retired %0d error %b want 1 0 0000 0 0 0",
               in_ready, proc_run, proc_instr, busy, retired, error);
    end
  endtask

  task automatic test_single_mv();
    do_reset();
    push_wait(16'h2005);
    @(posedge clk);
    #1;
    vectors++;
    if (proc_run !== 1'b1 || proc_instr !== 16'h2005) begin
      miscompares++;
      $display("FAIL mv_latency: run %b instr %h want 1 2005", proc_run, proc_instr);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (proc_run !== 1'b0) begin
      miscompares++;
      $display("FAIL mv_run_pulse: run %b want 0", proc_run);
    end
    wait_retired(8'd1, 20, "mv_retire");
    vectors++;
    if (r[0] !== 16'd5 || run_count != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mv_result: r0 %0d runs %0d busy %b want 5 1 0", r[0], run_count, busy);
    end
    check_order("mv");
  endtask

  task automatic test_stream();
    logic [15:0] prog [4];
    int gap;
    prog[0] = 16'h2003; prog[1] = 16'h6004; prog[2] = 16'hE002; prog[3] = 16'hA001;
    do_reset();
    for (int i = 0; i < 4; i++) push_wait(prog[i]);
    wait_retired(8'd4, 60, "stream_retire");
    vectors++;
    if (r[0] !== 16'd13 || b2b !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_result: r0 %0d b2b %b busy %b want 13 0 0", r[0], b2b, busy);
    end
    check_order("stream");
    for (int i = 0; i + 1 < run_cyc_q.size(); i++) begin
      gap = (prog[i][15:14] == MV) ? 4 : 6;
      vectors++;
      if (run_cyc_q[i+1] - run_cyc_q[i] != gap) begin
        miscompares++;
        $display("FAIL stream_round_trip%0d: %0d cycles want %0d", i, run_cyc_q[i+1] - run_cyc_q[i], gap);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] w;
    logic [15:0] e0, e1, opnd, res;
    do_reset();
    e0 = '0;
    e1 = '0;
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      if (i == 0) w[15:13] = 3'b001;
      repeat ($urandom_range(0, 6)) @(negedge clk);
      push_wait(w);
      opnd = w[13] ? {4'h0, w[11:0]} : (w[0] ? e1 : e0);
      res  = alu(w[15:14], w[12] ? e1 : e0, opnd);
      if (w[12]) e1 = res; else e0 = res;
    end
    wait_retired(8'd24, 400, "rand_retire");
    vectors++;
    if (r[0] !== e0 || r[1] !== e1 || b2b !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_result: r0 %h r1 %h b2b %b busy %b want %h %h 0 0", r[0], r[1], b2b, busy, e0, e1);
    end
    check_order("rand");
  endtask

  task automatic test_full();
    logic acc;
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(16'h2000 | 16'(i), acc);
      vectors++;
      if (acc !== (i < 9)) begin
        miscompares++;
        $display("FAIL full_push%0d: accepted %b want %b", i, acc, (i < 9));
      end
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL full_ready: in_ready %b busy %b want 0 1", in_ready, busy);
    end
    stall = 1'b0;
  endtask

  task automatic test_timeout();
    logic acc;
    int n;
    int runs;
    do_reset();
    stall = 1'b1;
    push_wait(16'h2001);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (proc_run !== 1'b1 && n < 10);
    vectors++;
    if (proc_run !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_issue: run %b want 1", proc_run);
    end
    repeat (TIMEOUT) @(posedge clk);
    #1;
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: error %b want 0", error);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (error !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_edge: error %b want 1", error);
    end
    runs = run_count;
    stall = 1'b0;
    push(16'h2002, acc);
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if (acc !== 1'b1 || run_count != runs || error !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_absorb: acc %b runs %0d error %b busy %b want 1 %0d 1 1",
               acc, run_count, error, busy, runs);
    end
    do_reset();
    #1;
    vectors++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: error %b busy %b want 0 0", error, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    push_wait(16'h2007);
    push_wait(16'h2008);
    wait_retired(8'd2, 40, "midwait_pre");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_wait(16'h6001);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, proc_run, proc_instr, busy, retired, error} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL midwait_reset: ready %b run %b instr %h busy %b retired %0d error %b want 1 0 0000 0 0 0",
               in_ready, proc_run, proc_instr, busy, retired, error);
    end
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    clear_logs();
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (run_count != 0 || retired !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_after: runs %0d retired %0d busy %b want 0 0 0", run_count, retired, busy);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      w = 16'h2000 | 16'($urandom_range(0, 4095));
      push_wait(w);
    end
    wait_retired(8'd255, 1500, "wrap_255");
    w = 16'h2ABC;
    push_wait(w);
    wait_retired(8'd0, 20, "wrap_zero");
    vectors++;
    if (r[0] !== 16'h0ABC || run_count != 256 || b2b !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_result: r0 %h runs %0d b2b %b want 0abc 256 0", r[0], run_count, b2b);
    end
    @(negedge clk);
    spurious = 1'b1;
    @(negedge clk);
    spurious = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (retired !== 8'd0 || busy !== 1'b0 || proc_run !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_spurious: retired %0d busy %b run %b want 0 0 0", retired, busy, proc_run);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_mv();
    test_stream();
    test_random_stream();
    test_full();
    test_timeout();
    test_reset_mid_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
